// File: rtl/tlb_mmu.sv
// Purpose: 16-entry fully associative MIPS32 joint TLB with fetch/data search ports, tlbr read, tlbwi/tlbwr write and tlbp probe.
// Latency: search and read 0 cycles, write visible 1 cycle after the we edge, probe result 1 cycle after p_req.
// Backpressure: none; every port accepts a request every cycle and the probe never stalls.
module tlb_mmu #(
  parameter int TLBNUM = 16
) (
  input  logic        clk,
  input  logic        resetn,
  // search port 0 (fetch)
  input  logic [18:0] s0_vpn2,
  input  logic        s0_odd_page,
  input  logic [7:0]  s0_asid,
  output logic        s0_found,
  output logic [3:0]  s0_index,
  output logic [19:0] s0_pfn,
  output logic [2:0]  s0_c,
  output logic        s0_d,
  output logic        s0_v,
  // search port 1 (data)
  input  logic [18:0] s1_vpn2,
  input  logic        s1_odd_page,
  input  logic [7:0]  s1_asid,
  output logic        s1_found,
  output logic [3:0]  s1_index,
  output logic [19:0] s1_pfn,
  output logic [2:0]  s1_c,
  output logic        s1_d,
  output logic        s1_v,
  // write port
  input  logic        we,
  input  logic [3:0]  w_index,
  input  logic [18:0] w_vpn2,
  input  logic [7:0]  w_asid,
  input  logic [19:0] w_pfn0,
  input  logic [2:0]  w_c0,
  input  logic        w_d0,
  input  logic        w_v0,
  input  logic        w_g0,
  input  logic [19:0] w_pfn1,
  input  logic [2:0]  w_c1,
  input  logic        w_d1,
  input  logic        w_v1,
  input  logic        w_g1,
  // read port
  input  logic [3:0]  r_index,
  output logic [18:0] r_vpn2,
  output logic [7:0]  r_asid,
  output logic [19:0] r_pfn0,
  output logic [2:0]  r_c0,
  output logic        r_d0,
  output logic        r_v0,
  output logic        r_g0,
  output logic [19:0] r_pfn1,
  output logic [2:0]  r_c1,
  output logic        r_d1,
  output logic        r_v1,
  output logic        r_g1,
  // probe port
  input  logic        p_req,
  input  logic [18:0] p_vpn2,
  input  logic [7:0]  p_asid,
  output logic        p_done,
  output logic        p_found,
  output logic [3:0]  p_index
);

  logic [18:0] vpn2_q [TLBNUM];
  logic [18:0] vpn2_d [TLBNUM];
  logic [7:0]  asid_q [TLBNUM];
  logic [7:0]  asid_d [TLBNUM];
  logic        g_q    [TLBNUM];
  logic        g_d    [TLBNUM];
  logic [19:0] pfn0_q [TLBNUM];
  logic [19:0] pfn0_d [TLBNUM];
  logic [2:0]  c0_q   [TLBNUM];
  logic [2:0]  c0_d   [TLBNUM];
  logic        d0_q   [TLBNUM];
  logic        d0_d   [TLBNUM];
  logic        v0_q   [TLBNUM];
  logic        v0_d   [TLBNUM];
  logic [19:0] pfn1_q [TLBNUM];
  logic [19:0] pfn1_d [TLBNUM];
  logic [2:0]  c1_q   [TLBNUM];
  logic [2:0]  c1_d   [TLBNUM];
  logic        d1_q   [TLBNUM];
  logic        d1_d   [TLBNUM];
  logic        v1_q   [TLBNUM];
  logic        v1_d   [TLBNUM];

  logic              p_done_q, p_done_d;
  logic              p_found_q, p_found_d;
  logic [3:0]        p_index_q, p_index_d;

  logic [TLBNUM-1:0] s0_match, s1_match, p_match;
  logic [4:0]        s0_sel, s1_sel, p_sel;

  // Lowest set bit wins: returns {hit, index}, index 0 on a miss.
  function automatic logic [4:0] prio_sel(input logic [TLBNUM-1:0] m);
    logic [4:0] r;
    r = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (m[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  // Next array contents: only the addressed entry takes the write data; g is the AND of both halves.
  always_comb begin
    vpn2_d = vpn2_q; asid_d = asid_q; g_d = g_q;
    pfn0_d = pfn0_q; c0_d = c0_q; d0_d = d0_q; v0_d = v0_q;
    pfn1_d = pfn1_q; c1_d = c1_q; d1_d = d1_q; v1_d = v1_q;
    if (we) begin
      vpn2_d[w_index] = w_vpn2;
      asid_d[w_index] = w_asid;
      g_d[w_index]    = w_g0 & w_g1;
      pfn0_d[w_index] = w_pfn0;
      c0_d[w_index]   = w_c0;
      d0_d[w_index]   = w_d0;
      v0_d[w_index]   = w_v0;
      pfn1_d[w_index] = w_pfn1;
      c1_d[w_index]   = w_c1;
      d1_d[w_index]   = w_d1;
      v1_d[w_index]   = w_v1;
    end
  end

  // Per-entry match vectors for both search ports and the probe key.
  always_comb begin
    s0_match = '0;
    s1_match = '0;
    p_match  = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      s0_match[i] = (vpn2_q[i] == s0_vpn2) && (g_q[i] || asid_q[i] == s0_asid);
      s1_match[i] = (vpn2_q[i] == s1_vpn2) && (g_q[i] || asid_q[i] == s1_asid);
      p_match[i]  = (vpn2_q[i] == p_vpn2)  && (g_q[i] || asid_q[i] == p_asid);
    end
    s0_sel = prio_sel(s0_match);
    s1_sel = prio_sel(s1_match);
    p_sel  = prio_sel(p_match);
  end

  // Search outputs: pick the even/odd page of the winning entry, all-zero on a miss.
  always_comb begin
    s0_found = s0_sel[4];
    s0_index = s0_sel[3:0];
    s0_pfn = '0; s0_c = '0; s0_d = 1'b0; s0_v = 1'b0;
    if (s0_sel[4]) begin
      s0_pfn = s0_odd_page ? pfn1_q[s0_sel[3:0]] : pfn0_q[s0_sel[3:0]];
      s0_c   = s0_odd_page ? c1_q[s0_sel[3:0]]   : c0_q[s0_sel[3:0]];
      s0_d   = s0_odd_page ? d1_q[s0_sel[3:0]]   : d0_q[s0_sel[3:0]];
      s0_v   = s0_odd_page ? v1_q[s0_sel[3:0]]   : v0_q[s0_sel[3:0]];
    end
    s1_found = s1_sel[4];
    s1_index = s1_sel[3:0];
    s1_pfn = '0; s1_c = '0; s1_d = 1'b0; s1_v = 1'b0;
    if (s1_sel[4]) begin
      s1_pfn = s1_odd_page ? pfn1_q[s1_sel[3:0]] : pfn0_q[s1_sel[3:0]];
      s1_c   = s1_odd_page ? c1_q[s1_sel[3:0]]   : c0_q[s1_sel[3:0]];
      s1_d   = s1_odd_page ? d1_q[s1_sel[3:0]]   : d0_q[s1_sel[3:0]];
      s1_v   = s1_odd_page ? v1_q[s1_sel[3:0]]   : v0_q[s1_sel[3:0]];
    end
  end

  // tlbr read data straight from the array; both g outputs report the single stored g.
  always_comb begin
    r_vpn2 = vpn2_q[r_index];
    r_asid = asid_q[r_index];
    r_g0   = g_q[r_index];
    r_g1   = g_q[r_index];
    r_pfn0 = pfn0_q[r_index];
    r_c0   = c0_q[r_index];
    r_d0   = d0_q[r_index];
    r_v0   = v0_q[r_index];
    r_pfn1 = pfn1_q[r_index];
    r_c1   = c1_q[r_index];
    r_d1   = d1_q[r_index];
    r_v1   = v1_q[r_index];
  end

  // Probe result stage: done pulses per request, found/index hold until the next request.
  always_comb begin
    p_done_d  = p_req;
    p_found_d = p_req ? p_sel[4]   : p_found_q;
    p_index_d = p_req ? p_sel[3:0] : p_index_q;
  end

  // State update; reset clears every entry and cancels any pending probe result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < TLBNUM; i++) begin
        vpn2_q[i] <= '0; asid_q[i] <= '0; g_q[i] <= 1'b0;
        pfn0_q[i] <= '0; c0_q[i] <= '0; d0_q[i] <= 1'b0; v0_q[i] <= 1'b0;
        pfn1_q[i] <= '0; c1_q[i] <= '0; d1_q[i] <= 1'b0; v1_q[i] <= 1'b0;
      end
      p_done_q  <= 1'b0;
      p_found_q <= 1'b0;
      p_index_q <= '0;
    end else begin
      vpn2_q <= vpn2_d; asid_q <= asid_d; g_q <= g_d;
      pfn0_q <= pfn0_d; c0_q <= c0_d; d0_q <= d0_d; v0_q <= v0_d;
      pfn1_q <= pfn1_d; c1_q <= c1_d; d1_q <= d1_d; v1_q <= v1_d;
      p_done_q  <= p_done_d;
      p_found_q <= p_found_d;
      p_index_q <= p_index_d;
    end
  end

  assign p_done  = p_done_q;
  assign p_found = p_found_q;
  assign p_index = p_index_q;

endmodule

// File: tb/tb_tlb_mmu.sv
// Directed bench for tlb_mmu: reset contents, write/search/read, global bit, duplicates, probe timing, reset mid-stream.
// Inputs change 1 time unit after the rising edge, outputs are sampled 2 units after it.
// The DUT never stalls, so every wait is a fixed number of clock edges.
module tb_tlb_mmu;

  logic        clk = 1'b0;
  logic        resetn;
  logic [18:0] s0_vpn2, s1_vpn2, p_vpn2, w_vpn2, r_vpn2;
  logic        s0_odd_page, s1_odd_page;
  logic [7:0]  s0_asid, s1_asid, p_asid, w_asid, r_asid;
  logic        s0_found, s1_found, p_done, p_found, p_req, we;
  logic [3:0]  s0_index, s1_index, p_index, w_index, r_index;
  logic [19:0] s0_pfn, s1_pfn, w_pfn0, w_pfn1, r_pfn0, r_pfn1;
  logic [2:0]  s0_c, s1_c, w_c0, w_c1, r_c0, r_c1;
  logic        s0_d, s0_v, s1_d, s1_v;
  logic        w_d0, w_v0, w_g0, w_d1, w_v1, w_g1;
  logic        r_d0, r_v0, r_g0, r_d1, r_v1, r_g1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tlb_mmu dut (
    .clk(clk), .resetn(resetn),
    .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn), .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn), .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0), .w_g0(w_g0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1), .w_g1(w_g1),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0), .r_g0(r_g0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1), .r_g1(r_g1),
    .p_req(p_req), .p_vpn2(p_vpn2), .p_asid(p_asid),
    .p_done(p_done), .p_found(p_found), .p_index(p_index)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stage write data; the entry updates at the next rising edge while we=1.
  task automatic set_wr(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                        input logic [19:0] pfn0, input logic d0, input logic v0, input logic g0,
                        input logic [19:0] pfn1, input logic d1, input logic v1, input logic g1);
    we = 1'b1; w_index = idx; w_vpn2 = vpn2; w_asid = asid;
    w_pfn0 = pfn0; w_c0 = 3'd0; w_d0 = d0; w_v0 = v0; w_g0 = g0;
    w_pfn1 = pfn1; w_c1 = 3'd3; w_d1 = d1; w_v1 = v1; w_g1 = g1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; we = 1'b0; p_req = 1'b0;
    s0_vpn2 = '0; s0_odd_page = 1'b0; s0_asid = '0;
    s1_vpn2 = '0; s1_odd_page = 1'b0; s1_asid = '0;
    p_vpn2 = '0; p_asid = '0; r_index = '0;
    w_index = '0; w_vpn2 = '0; w_asid = '0;
    w_pfn0 = '0; w_c0 = '0; w_d0 = 1'b0; w_v0 = 1'b0; w_g0 = 1'b0;
    w_pfn1 = '0; w_c1 = '0; w_d1 = 1'b0; w_v1 = 1'b0; w_g1 = 1'b0;
    step(); step();
    resetn = 1'b1;
    #1;
    // Reset contents: all-zero key gives an invalid hit at index 0, anything else misses.
    chk("rst_s0_found", 32'(s0_found), 32'd1);
    chk("rst_s0_index", 32'(s0_index), 32'd0);
    chk("rst_s0_v", 32'(s0_v), 32'd0);
    chk("rst_p_done", 32'(p_done), 32'd0);
    s0_vpn2 = 19'h12345;
    #1;
    chk("rst_miss_found", 32'(s0_found), 32'd0);
    chk("rst_miss_pfn", 32'(s0_pfn), 32'd0);

    // Write entry 5; searching in the write cycle still sees the old contents.
    step();
    set_wr(4'd5, 19'h12345, 8'h07, 20'hABCDE, 1'b0, 1'b1, 1'b0, 20'h11111, 1'b1, 1'b1, 1'b0);
    s1_vpn2 = 19'h12345; s1_odd_page = 1'b1; s1_asid = 8'h07;
    #1;
    chk("wr_same_cycle_found", 32'(s1_found), 32'd0);
    step();
    we = 1'b0;
    #1;
    chk("odd_found", 32'(s1_found), 32'd1);
    chk("odd_index", 32'(s1_index), 32'd5);
    chk("odd_pfn", 32'(s1_pfn), 32'h11111);
    chk("odd_c", 32'(s1_c), 32'd3);
    chk("odd_d", 32'(s1_d), 32'd1);
    chk("odd_v", 32'(s1_v), 32'd1);
    s1_odd_page = 1'b0;
    #1;
    chk("even_pfn", 32'(s1_pfn), 32'hABCDE);
    chk("even_d", 32'(s1_d), 32'd0);
    chk("even_v", 32'(s1_v), 32'd1);
    s1_asid = 8'h08;
    #1;
    chk("asid_miss_found", 32'(s1_found), 32'd0);
    chk("asid_miss_index", 32'(s1_index), 32'd0);
    r_index = 4'd5;
    #1;
    chk("rd_vpn2", 32'(r_vpn2), 32'h12345);
    chk("rd_asid", 32'(r_asid), 32'h07);

    // Global bit is stored only when both halves are global.
    step();
    set_wr(4'd5, 19'h12345, 8'h07, 20'hABCDE, 1'b0, 1'b1, 1'b1, 20'h11111, 1'b1, 1'b1, 1'b0);
    step();
    we = 1'b0;
    #1;
    chk("g_half_r_g0", 32'(r_g0), 32'd0);
    chk("g_half_r_g1", 32'(r_g1), 32'd0);
    chk("g_half_found", 32'(s1_found), 32'd0);
    step();
    set_wr(4'd5, 19'h12345, 8'h07, 20'hABCDE, 1'b0, 1'b1, 1'b1, 20'h11111, 1'b1, 1'b1, 1'b1);
    step();
    we = 1'b0;
    #1;
    chk("g_full_r_g0", 32'(r_g0), 32'd1);
    chk("g_full_found", 32'(s1_found), 32'd1);
    chk("g_full_index", 32'(s1_index), 32'd5);

    // Duplicate vpn2 in entries 3 and 9: the lower index wins everywhere.
    step();
    set_wr(4'd9, 19'h00AAA, 8'h01, 20'h00999, 1'b0, 1'b1, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
    step();
    set_wr(4'd3, 19'h00AAA, 8'h01, 20'h00333, 1'b0, 1'b1, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
    step();
    we = 1'b0;
    s0_vpn2 = 19'h00AAA; s0_asid = 8'h01; s0_odd_page = 1'b0;
    s1_vpn2 = 19'h00AAA; s1_asid = 8'h01;
    p_vpn2 = 19'h00AAA; p_asid = 8'h01; p_req = 1'b1;
    #1;
    chk("dup_s0_index", 32'(s0_index), 32'd3);
    chk("dup_s0_pfn", 32'(s0_pfn), 32'h00333);
    chk("dup_s1_index", 32'(s1_index), 32'd3);
    step();
    p_req = 1'b0;
    #1;
    chk("dup_p_done", 32'(p_done), 32'd1);
    chk("dup_p_found", 32'(p_found), 32'd1);
    chk("dup_p_index", 32'(p_index), 32'd3);
    step();
    #1;
    chk("p_done_pulse", 32'(p_done), 32'd0);
    chk("p_found_hold", 32'(p_found), 32'd1);
    chk("p_index_hold", 32'(p_index), 32'd3);

    // Probe alongside a write that moves entry 5 away: probe uses pre-write contents.
    set_wr(4'd5, 19'h54321, 8'h07, 20'h0, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
    p_req = 1'b1; p_vpn2 = 19'h12345; p_asid = 8'h07; r_index = 4'd5;
    #1;
    chk("rd_old_same_cycle", 32'(r_vpn2), 32'h12345);
    step();
    we = 1'b0;
    #1;
    chk("pw_p_done", 32'(p_done), 32'd1);
    chk("pw_p_found", 32'(p_found), 32'd1);
    chk("pw_p_index", 32'(p_index), 32'd5);
    chk("rd_new", 32'(r_vpn2), 32'h54321);
    step();
    p_req = 1'b0;
    #1;
    chk("rep_p_done", 32'(p_done), 32'd1);
    chk("rep_p_found", 32'(p_found), 32'd0);
    chk("rep_p_index", 32'(p_index), 32'd0);

    // Back-to-back probes, then reset while the stream is in flight.
    p_vpn2 = 19'h00AAA; p_asid = 8'h01; p_req = 1'b1;
    step();
    #1;
    chk("b2b_done_1", 32'(p_done), 32'd1);
    step();
    #1;
    chk("b2b_done_2", 32'(p_done), 32'd1);
    step();
    #1;
    chk("b2b_done_3", 32'(p_done), 32'd1);
    chk("b2b_index_3", 32'(p_index), 32'd3);
    resetn = 1'b0;
    #1;
    chk("arst_p_done", 32'(p_done), 32'd0);
    chk("arst_p_found", 32'(p_found), 32'd0);
    chk("arst_p_index", 32'(p_index), 32'd0);
    for (int i = 0; i < 16; i++) begin
      r_index = 4'(i);
      #1;
      chk($sformatf("arst_entry_%0d", i),
          32'(|{r_vpn2, r_asid, r_pfn0, r_c0, r_d0, r_v0, r_g0, r_pfn1, r_c1, r_d1, r_v1, r_g1}), 32'd0);
    end
    p_req = 1'b0;
    step();
    resetn = 1'b1;
    step();
    #1;
    chk("post_rst_p_done", 32'(p_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tlb_mmu.md
# tlb_mmu

16-entry, fully associative MIPS32-style joint TLB. It sits beside the CP0 register block: it consumes the EntryHi/EntryLo0/EntryLo1/Index values that CP0 drives for tlbwi/tlbwr, and produces the tlbr read data and tlbp probe result that CP0 latches. It also provides two same-cycle translation search ports, one for instruction fetch and one for data access. The block holds the only copy of the TLB array and a registered probe-result stage.

## Interface
- TLBNUM, 16: number of entries; index width is fixed at 4 bits.
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- s0_vpn2 / s1_vpn2  in  19  search VA[31:13]; port 0 = fetch, port 1 = data.
- s0_odd_page / s1_odd_page  in  1  search VA[12]; selects page 1 when high.
- s0_asid / s1_asid  in  8  current ASID (EntryHi.ASID).
- s0_found / s1_found  out  1  match hit.
- s0_index / s1_index  out  4  index of the matching entry.
- s0_pfn / s1_pfn  out  20; s0_c / s1_c out 3; s0_d, s0_v, s1_d, s1_v  out  1  selected page attributes.
- we  in  1  write strobe (tlbwi/tlbwr committed).
- w_index  in  4  target entry.
- w_vpn2 19, w_asid 8, w_pfn0 20, w_c0 3, w_d0, w_v0, w_g0, w_pfn1 20, w_c1 3, w_d1, w_v1, w_g1  in  write data from EntryHi/EntryLo0/EntryLo1.
- r_index  in  4  read index (Index.Index).
- r_vpn2, r_asid, r_pfn0, r_c0, r_d0, r_v0, r_g0, r_pfn1, r_c1, r_d1, r_v1, r_g1  out  read data; widths match the write data.
- p_req  in  1  probe request (tlbp in MEM, valid, no exception).
- p_vpn2  in  19; p_asid  in  8  probe key from EntryHi.
- p_done  out  1  probe result valid, one-cycle pulse.
- p_found  out  1  probe hit.
- p_index  out  4  index of the hit.

## Operation
- Each entry stores vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1.
- g is stored as w_g0 & w_g1. r_g0 and r_g1 both return the stored g.
- Match rule for entry i: entry.vpn2 == key.vpn2 && (entry.g || entry.asid == key.asid).
- Multiple matches (a software error) resolve deterministically: the lowest matching index wins on all ports.
- Search ports:
  - found = OR of the per-entry matches.
  - index = the winning entry.
  - odd_page=0 returns the pfn0/c0/d0/v0 fields; odd_page=1 returns the pfn1/c1/d1/v1 fields.
  - On a miss, index, pfn, c, d and v are all 0.
- Write: on a clk edge with we=1, entry[w_index] takes all w_* fields. All other entries are unchanged.
- Read: r_* = entry[r_index], purely combinational.
- Probe:
  - With p_req=1 at edge N, the block registers a match of p_vpn2/p_asid against the array contents before edge N.
  - At N+1: p_done=1, p_found = hit, p_index = winning index, or 0 on a miss.
  - p_done is high for exactly one cycle per request. Back-to-back requests give back-to-back results.
  - p_found/p_index hold their value until the next p_done.
- Reset (asynchronous, resetn=0):
  - Every field of every entry is cleared to 0.
  - p_done=0, p_found=0, p_index=0.
  - Consequence: after reset, a search with vpn2=0 and asid=0 gets found=1, index=0, v=0 (an invalid hit). Any other key misses.
- Simultaneous events:
  - A write and a probe in the same cycle: the probe sees pre-write contents.
  - A write and a search or read of the same entry in the same cycle: the search or read returns old contents. New contents are visible from the next cycle.
  - resetn asserted while a probe is in flight: the pending p_done is cancelled.

## Timing
- Search and read latency is 0 cycles (combinational). The critical path is a 16-way compare followed by a priority select and a mux.
- Write latency is 1 cycle: visible to search, read and probe in the cycle after the we edge.
- Probe latency is 1 cycle, fixed. There is no back-pressure and no busy state.
- resetn is asserted asynchronously and released synchronously to clk by the top level.

## Test plan
- Reset, then search s0 with vpn2=0x00000, asid=0x00 and another with vpn2=0x12345 -> the first gives found=1, index=0, v=0; the second gives found=0, pfn=0. p_done=0.
- Write index 5: vpn2=0x12345, asid=0x07, g0=g1=0, pfn0=0xABCDE, v0=1, pfn1=0x11111, d1=1, v1=1.
  - Same cycle: s1 search misses.
  - Next cycle: s1 (0x12345, odd=1, asid=0x07) gives found=1, index=5, pfn=0x11111, d=1, v=1.
  - With asid=0x08 the same search misses.
- Rewrite index 5 with g0=1, g1=0 -> r_g0=r_g1=0 and an asid=0x08 search still misses. Rewrite with g0=g1=1 -> the asid=0x08 search hits.
- Duplicate vpn2 0x00AAA in entries 3 and 9 -> s0, s1 and the probe all report index=3.
- p_req with key 0x12345/0x07 in the same cycle as a write that changes entry 5's vpn2 -> next cycle p_done=1, p_found=1, p_index=5. A repeat probe gives p_found=0, p_index=0.
- p_req pulses on 3 consecutive cycles -> 3 consecutive p_done cycles. Assert resetn=0 mid-stream -> p_done drops immediately and all entries read back 0.
